// File: rtl/program_encoder.sv
// Packs decoded instruction fields into 16-bit ISA words and streams them to
// program memory at consecutive addresses through a small registered FIFO.
module program_encoder #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int FIFO_DEPTH            = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] base_addr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [3:0]                       in_opcode,
    input  logic [3:0]                       in_rd,
    input  logic [3:0]                       in_rs,
    input  logic [3:0]                       in_rt,
    input  logic [7:0]                       in_imm8,
    input  logic [3:0]                       in_cond,
    output logic                             mem_write_valid,
    input  logic                             mem_write_ready,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_write_address,
    output logic [15:0]                      mem_write_data,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       error_code,
    output logic [PROGRAM_MEM_ADDR_BITS:0]   instr_count
);
    localparam int N  = PROGRAM_MEM_ADDR_BITS;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01, ERR_OVERFLOW = 2'b10} err_t;

    state_t         r_state;
    err_t           r_error_code;
    logic [N-1:0]   r_wr_addr;
    logic [N:0]     r_instr_count;
    logic           r_error;
    logic           r_done;
    logic [N-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [15:0]    r_fifo_data [FIFO_DEPTH];
    logic [PW:0]    r_wr_ptr;
    logic [PW:0]    r_rd_ptr;

    logic           w_legal;
    logic [15:0]    w_word;
    logic           w_empty;
    logic           w_full;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic           w_at_top;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_legal = 1'b1;
        w_word  = 16'h0000;
        case (in_opcode)
            4'h0:                   w_word = 16'h0000;
            4'h1:                   w_word = {4'h1, in_cond, in_imm8};
            4'h2:                   w_word = {4'h2, 4'h0, in_rs, in_rt};
            4'h3, 4'h4, 4'h5, 4'h6: w_word = {in_opcode, in_rd, in_rs, in_rt};
            4'h7:                   w_word = {4'h7, in_rd, in_rs, 4'h0};
            4'h8:                   w_word = {4'h8, 4'h0, in_rs, in_rt};
            4'h9:                   w_word = {4'h9, in_rd, in_imm8};
            4'hF:                   w_word = 16'hF000;
            default:                w_legal = 1'b0;
        endcase
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign in_ready = (r_state == S_LOAD) && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = !w_empty && mem_write_ready;
    assign w_at_top = (r_wr_addr == {N{1'b1}});

    assign mem_write_valid   = !w_empty;
    assign mem_write_address = w_empty ? '0 : r_fifo_addr[r_rd_ptr[PW-1:0]];
    assign mem_write_data    = w_empty ? '0 : r_fifo_data[r_rd_ptr[PW-1:0]];
    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;
    assign error             = r_error;
    assign error_code        = r_error_code;
    assign instr_count       = r_instr_count;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define validity and outputs are gated when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[PW-1:0]] <= r_wr_addr;
            r_fifo_data[r_wr_ptr[PW-1:0]] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_addr     <= '0;
            r_instr_count <= '0;
            r_error       <= 1'b0;
            r_error_code  <= ERR_NONE;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state       <= S_LOAD;
                    r_wr_addr     <= base_addr;
                    r_instr_count <= '0;
                    r_error       <= 1'b0;
                    r_error_code  <= ERR_NONE;
                end
                S_LOAD: if (w_accept) begin
                    if (!w_legal) begin
                        r_error <= 1'b1;
                        if (!r_error) r_error_code <= ERR_ILLEGAL;
                    end else begin
                        r_instr_count <= r_instr_count + (N+1)'(1);
                        if (!w_at_top) r_wr_addr <= r_wr_addr + N'(1);
                        if (in_opcode == 4'hF) begin
                            r_state <= S_DRAIN;
                        end else if (w_at_top) begin
                            // Last address consumed: stop loading rather than wrap.
                            r_state <= S_DRAIN;
                            r_error <= 1'b1;
                            if (!r_error) r_error_code <= ERR_OVERFLOW;
                        end
                    end
                end
                S_DRAIN: if (w_empty) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
